// File: rtl/mul_seq.sv
// Sequential signed OPSIZE x OPSIZE multiplier using radix-2 Booth recoding, one iteration per clock.
// Result appears OPSIZE edges after start is captured; start is ignored while busy (ready=0).
module mul_seq #(
  parameter int OPSIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [OPSIZE-1:0]     a,
  input  logic [OPSIZE-1:0]     b,
  output logic [2*OPSIZE-1:0]   out,
  output logic                  ready
);

  localparam int CW = $clog2(OPSIZE + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [OPSIZE:0]   mcand;
  logic [OPSIZE:0]   hi;
  logic [OPSIZE-1:0] lo;
  logic              q_1;
  logic [CW-1:0]     cnt;

  logic [OPSIZE:0]     hi_sum;
  logic [2*OPSIZE+1:0] shifted;
  logic                capture;
  logic                done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Booth step: the upper half is one bit wider than the operand so that
  // subtracting the most-negative multiplicand cannot wrap.
  always_comb begin
    hi_sum = hi;
    case ({lo[0], q_1})
      2'b01:   hi_sum = hi + mcand;
      2'b10:   hi_sum = hi - mcand;
      default: hi_sum = hi;
    endcase
    shifted = $signed({hi_sum, lo, q_1}) >>> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      out   <= '0;
      ready <= 1'b1;
    end else if (capture) begin
      mcand <= {a[OPSIZE-1], a};
      hi    <= '0;
      lo    <= b;
      q_1   <= 1'b0;
      cnt   <= CW'(OPSIZE);
      ready <= 1'b0;
    end else if (state == BUSY) begin
      hi  <= shifted[2*OPSIZE+1:OPSIZE+1];
      lo  <= shifted[OPSIZE:1];
      q_1 <= shifted[0];
      cnt <= cnt - CW'(1);
      if (done) begin
        out   <= shifted[2*OPSIZE:1];
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: a cycle model predicts acceptance, busy window and each product.
module tb_mul_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [7:0]  a;
  logic signed [7:0]  b;
  logic [15:0]        out;
  logic               ready;

  int                 n_assert = 0;
  int                 n_fail   = 0;
  logic [15:0]        exp_q[$];
  logic [15:0]        exp_out  = '0;
  int                 m_cnt    = 0;
  logic               ready_prev = 1'b1;
  logic               mon_en   = 1'b0;
  logic [15:0]        acc_sum  = '0;

  mul_seq #(.OPSIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .out   (out),
    .ready (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] prod(input logic signed [7:0] x, input logic signed [7:0] y);
    logic signed [15:0] p;
    p = x * y;
    return p;
  endfunction

  // Cycle model, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_cnt      = 0;
      exp_q.delete();
      exp_out    = '0;
      ready_prev = 1'b1;
    end else if (mon_en) begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (exp_q.size() == 0) check("sb_underflow", 1, 0);
          else                   exp_out = exp_q.pop_front();
        end
      end else if (start) begin
        exp_q.push_back(prod(a, b));
        m_cnt = 8;
      end
      check("ready", {31'b0, ready}, {31'b0, (m_cnt == 0)});
      check("out", {16'b0, out}, {16'b0, exp_out});
      if (ready && !ready_prev) acc_sum += out;
      ready_prev = ready;
    end
  end

  task automatic do_op(input logic signed [7:0] x, input logic signed [7:0] y,
                       input logic [15:0] exp, input string tag);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check(tag, {16'b0, out}, {16'b0, exp});
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
    #7 rst_n = 1'b0;
    #1;
    check("rst_out", {16'b0, out}, 0);
    check("rst_ready", {31'b0, ready}, 1);
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_out", {16'b0, out}, 0);

    acc_sum = '0;
    do_op(48, 110, 16'h14A0, "q_pp");
    do_op(48, -110, 16'hEB60, "q_pn");
    do_op(-48, 110, 16'hEB60, "q_np");
    do_op(-48, -110, 16'h14A0, "q_nn");
    do_op(-1, -1, 16'h0001, "m1m1");
    do_op(127, 127, 16'h3F01, "max_max");
    check("acc_sum", {16'b0, acc_sum}, 32'h3F02);
    do_op(-128, -128, 16'h4000, "min_min");
    do_op(-128, 127, 16'hC080, "min_max");
    do_op(0, -77, 16'h0000, "zero");

    // Second start during busy must be dropped.
    @(negedge clk);
    a = 5; b = 6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 9; b = 9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("busy_ignore", {16'b0, out}, 30);

    a = 7; b = -3; start = 1'b1;
    repeat (40) @(negedge clk);
    a = -9; b = 12;
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("held_last", {16'b0, out}, {16'b0, prod(-9, 12)});

    // Abort in flight.
    @(negedge clk);
    a = 100; b = 100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out", {16'b0, out}, 0);
    check("abort_ready", {31'b0, ready}, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3, -4, 16'hFFF4, "post_abort");

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential signed (two's-complement) multiplier, OPSIZE x OPSIZE -> 2*OPSIZE.
- Computes one product per start request using an iterative radix-2 (Booth or equivalent) algorithm, one iteration per clock.
- Feeds a multiply-accumulate stage, which adds `out` to its accumulator on the rising edge of `ready`.

Parameters:
- OPSIZE, 8, operand width in bits (>= 2). The product width is 2*OPSIZE.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a multiplication; sampled only while ready=1.
- a, input, OPSIZE, multiplicand, signed two's complement.
- b, input, OPSIZE, multiplier, signed two's complement.
- out, output, 2*OPSIZE, signed product of the most recently completed operation (registered).
- ready, output, 1, 1 = idle or result valid; 0 = busy (registered).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, takes effect immediately, independent of clk):
  - out=0, ready=1, FSM in IDLE.
  - Internal operand, counter and accumulator registers are cleared.
- Reset asserted mid-operation aborts the operation. No result is produced and out stays 0.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - ready=1.
  - On a clk edge with start=1: capture a and b into internal registers, clear the partial product, load the iteration counter with OPSIZE, go to BUSY.
  - ready=0 from that edge on.
- BUSY:
  - ready=0.
  - Each edge performs one radix-2 iteration and decrements the counter.
  - On the OPSIZE-th edge after the capture edge, in the same edge:
    - out takes the final product;
    - ready returns to 1;
    - FSM returns to IDLE.
  - ready is therefore low for exactly OPSIZE cycles per operation.
- Latency: start sampled at edge N -> out valid and ready=1 after edge N+OPSIZE.
- out changes only at that completion edge. It holds its value in all other cycles, including during the next operation.
- start while BUSY is ignored and not queued. a and b may change freely after the capture edge.
- start held high continuously: a new operation is captured on the first edge after completion (the edge where ready=1 and start=1). Back-to-back throughput is one result per OPSIZE+1 cycles.
- Arithmetic:
  - Full signed product, exact in 2*OPSIZE bits for every operand pair, including -2^(OPSIZE-1) * -2^(OPSIZE-1) = 2^(2*OPSIZE-2).
  - Internal accumulator carries at least one guard bit (2*OPSIZE+1) so the most-negative case does not overflow during iterations.
  - No saturation; no overflow flag.
- No combinational path from any input to any output.

Test Plan:
- Reset/idle: assert rst_n=0 mid-clock -> out=0 and ready=1 immediately. Release rst_n with start=0 for 20 cycles -> out and ready unchanged.
- Signed quadrants (OPSIZE=8), one-cycle start pulse, then wait 15 cycles between operations:
  - 48*110 -> out=5280 (0x14A0);
  - 48*-110 -> -5280 (0xEB60);
  - -48*110 -> 0xEB60;
  - -48*-110 -> 0x14A0.
  - For each, ready low exactly 8 cycles, and out stable until ready rises.
- Corner values:
  - -1*-1 -> 0x0001;
  - 127*127 -> 16129 (0x3F01);
  - -128*-128 -> 16384 (0x4000);
  - -128*127 -> -16256 (0xC080);
  - 0*-77 -> 0.
- Busy rules: pulse start with 5*6; 3 cycles later change a/b to 9*9 and pulse start again -> second start ignored, out=30, ready low exactly 8 cycles. Then hold start=1 continuously -> each new operation is captured on the edge after ready rises, with results 8 cycles apart from each capture.
- Reset mid-operation: start 100*100, assert rst_n=0 four cycles later -> out=0, ready=1 immediately. After release, start 3*-4 -> out=0xFFF4 after 8 cycles.
- Accumulator integration: a downstream register adds out on each rising edge of ready. After the six operations 48*110, 48*-110, -48*110, -48*-110, -1*-1, 127*127, the accumulated sum equals 0x3F02 (mod 2^16).
